student_iic_target: RTL



---
 rtl/student_iic_target_if.sv | 13 +
 rtl/student_iic_target.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/student_iic_target_if.sv
// rtl/student_iic_target_if.sv - scl input and register-bank side signals of the I2C target
// sda stays a plain inout port on the target so open-drain resolution happens on a real net.
interface student_iic_target_if #(
   parameter int NUM_REGS = 4
);
   logic                  scl;
   logic [NUM_REGS*8-1:0] regs_o;
   logic                  wr_pulse_o;
   logic                  busy_o;

   modport slave (input scl, output regs_o, wr_pulse_o, busy_o);
   modport master (output scl, input regs_o, wr_pulse_o, busy_o);
endinterface

// File: rtl/student_iic_target.sv
// rtl/student_iic_target.sv - I2C target serving a small auto-incrementing register bank
// All bus decisions run on synchronized scl/sda; sda is only ever pulled low, never driven high.
module student_iic_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h42,
   parameter int         NUM_REGS    = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   inout  wire                  sda,
   student_iic_target_if.slave  bus
);
   localparam int PW = $clog2(NUM_REGS);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR     = 3'd1;
   localparam logic [2:0] S_ADDR_ACK = 3'd2;
   localparam logic [2:0] S_WR_DATA  = 3'd3;
   localparam logic [2:0] S_WR_ACK   = 3'd4;
   localparam logic [2:0] S_RD_DATA  = 3'd5;
   localparam logic [2:0] S_RD_ACK   = 3'd6;

   logic [2:0]            scl_sy, sda_sy;
   logic [2:0]            state_q;
   logic [2:0]            cnt_q;
   logic [7:0]            shift_q;
   logic [PW-1:0]         ptr_q;
   logic [NUM_REGS*8-1:0] regs_q;
   logic                  oe_q, busy_q, wr_pulse_q;
   logic                  rw_q, first_q, ack_on_q, rd_pend_q;

   logic       scl_rise, scl_fall, start_det, stop_det, sda_bit;
   logic [7:0] byte_in, rd_byte;

   // [1:0] synchronize, [2] is the history stage used for edge detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sy <= 3'b111;
         sda_sy <= 3'b111;
      end else begin
         scl_sy <= {scl_sy[1:0], bus.scl};
         sda_sy <= {sda_sy[1:0], sda};
      end
   end

   assign scl_rise  = scl_sy[1] & ~scl_sy[2];
   assign scl_fall  = ~scl_sy[1] & scl_sy[2];
   assign start_det = scl_sy[1] & scl_sy[2] & sda_sy[2] & ~sda_sy[1];
   assign stop_det  = scl_sy[1] & scl_sy[2] & ~sda_sy[2] & sda_sy[1];
   assign sda_bit   = sda_sy[1];
   assign byte_in   = {shift_q[6:0], sda_bit};
   assign rd_byte   = regs_q[{ptr_q, 3'b000} +: 8];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         shift_q    <= 8'd0;
         ptr_q      <= '0;
         regs_q     <= '0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         wr_pulse_q <= 1'b0;
         rw_q       <= 1'b0;
         first_q    <= 1'b0;
         ack_on_q   <= 1'b0;
         rd_pend_q  <= 1'b0;
      end else begin
         wr_pulse_q <= 1'b0;
         if (start_det) begin
            state_q   <= S_ADDR;
            oe_q      <= 1'b0;
            cnt_q     <= 3'd0;
            busy_q    <= 1'b0;
            ack_on_q  <= 1'b0;
            rd_pend_q <= 1'b0;
         end else if (stop_det) begin
            state_q   <= S_IDLE;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            ack_on_q  <= 1'b0;
            rd_pend_q <= 1'b0;
         end else begin
            case (state_q)
               S_ADDR: if (scl_rise) begin
                  shift_q <= byte_in;
                  cnt_q   <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     if (byte_in[7:1] == TARGET_ADDR) begin
                        rw_q    <= byte_in[0];
                        state_q <= S_ADDR_ACK;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
               S_ADDR_ACK: if (scl_fall) begin
                  if (!ack_on_q) begin
                     oe_q     <= 1'b1;
                     ack_on_q <= 1'b1;
                  end else begin
                     ack_on_q <= 1'b0;
                     busy_q   <= 1'b1;
                     cnt_q    <= 3'd0;
                     if (rw_q) begin
                        // first read bit goes out on the same edge that ends the ACK
                        oe_q    <= ~rd_byte[7];
                        shift_q <= {rd_byte[6:0], 1'b0};
                        ptr_q   <= ptr_q + PW'(1);
                        state_q <= S_RD_DATA;
                     end else begin
                        oe_q    <= 1'b0;
                        first_q <= 1'b1;
                        state_q <= S_WR_DATA;
                     end
                  end
               end
               S_WR_DATA: if (scl_rise) begin
                  shift_q <= byte_in;
                  cnt_q   <= cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     if (first_q) begin
                        ptr_q   <= byte_in[PW-1:0];
                        first_q <= 1'b0;
                     end else begin
                        regs_q[{ptr_q, 3'b000} +: 8] <= byte_in;
                        wr_pulse_q <= 1'b1;
                        ptr_q      <= ptr_q + PW'(1);
                     end
                     state_q <= S_WR_ACK;
                  end
               end
               S_WR_ACK: if (scl_fall) begin
                  if (!ack_on_q) begin
                     oe_q     <= 1'b1;
                     ack_on_q <= 1'b1;
                  end else begin
                     oe_q     <= 1'b0;
                     ack_on_q <= 1'b0;
                     cnt_q    <= 3'd0;
                     state_q  <= S_WR_DATA;
                  end
               end
               S_RD_DATA: if (scl_fall) begin
                  if (rd_pend_q) begin
                     oe_q      <= ~shift_q[7];
                     shift_q   <= {shift_q[6:0], 1'b0};
                     rd_pend_q <= 1'b0;
                     cnt_q     <= 3'd0;
                  end else if (cnt_q == 3'd7) begin
                     oe_q    <= 1'b0;
                     state_q <= S_RD_ACK;
                  end else begin
                     oe_q    <= ~shift_q[7];
                     shift_q <= {shift_q[6:0], 1'b0};
                     cnt_q   <= cnt_q + 3'd1;
                  end
               end
               S_RD_ACK: if (scl_rise) begin
                  if (!sda_bit) begin
                     shift_q   <= rd_byte;
                     ptr_q     <= ptr_q + PW'(1);
                     rd_pend_q <= 1'b1;
                     state_q   <= S_RD_DATA;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign sda            = oe_q ? 1'b0 : 1'bz;
   assign bus.regs_o     = regs_q;
   assign bus.wr_pulse_o = wr_pulse_q;
   assign bus.busy_o     = busy_q;
endmodule
